// File: rtl/cpu_pkg.sv
// cpu_pkg: core-wide widths and the sequential PC increment shared by fetch and PC_handler.
package cpu_pkg;
    localparam int INST_ADDR_WIDTH = 32;
    localparam int INST_WIDTH      = 32;
    localparam int PC_INC          = 4;
endpackage

// File: rtl/fetch_entry_ram.sv
// fetch_entry_ram: fetch queue storage, PC written on issue, instruction written on return.
module fetch_entry_ram #(
    parameter int INST_ADDR_WIDTH = cpu_pkg::INST_ADDR_WIDTH,
    parameter int INST_WIDTH      = cpu_pkg::INST_WIDTH,
    parameter int DEPTH           = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alloc_en,
    input  logic [$clog2(DEPTH)-1:0]   alloc_idx,
    input  logic [INST_ADDR_WIDTH-1:0] alloc_pc,
    input  logic                       fill_en,
    input  logic [$clog2(DEPTH)-1:0]   fill_idx,
    input  logic [INST_WIDTH-1:0]      fill_inst,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [INST_ADDR_WIDTH-1:0] rd_pc,
    output logic [INST_WIDTH-1:0]      rd_inst
);
    logic [INST_ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [INST_WIDTH-1:0]      inst_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else begin
            if (alloc_en) pc_mem[alloc_idx] <= alloc_pc;
            if (fill_en) inst_mem[fill_idx] <= fill_inst;
        end
    end

    assign rd_pc   = pc_mem[rd_idx];
    assign rd_inst = inst_mem[rd_idx];
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: issues PC fetches to instruction memory, tracks variable-latency returns,
// and presents them in order to decode; wrong-path returns after a flush are counted and dropped.
module inst_fetch_queue #(
    parameter int INST_ADDR_WIDTH = cpu_pkg::INST_ADDR_WIDTH,
    parameter int INST_WIDTH      = cpu_pkg::INST_WIDTH,
    parameter int DEPTH           = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [INST_ADDR_WIDTH-1:0] PC,
    input  logic                       inst_request_core2mem,
    input  logic                       flush,
    output logic [INST_ADDR_WIDTH-1:0] IF_PC_plus_4,
    output logic                       stall_PC,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [INST_ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [INST_WIDTH-1:0]      imem_rsp_data,
    output logic                       ID_valid,
    input  logic                       ID_ready,
    output logic [INST_WIDTH-1:0]      ID_inst,
    output logic [INST_ADDR_WIDTH-1:0] ID_PC
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW:0] DEPTH_LIM = (PW+1)'(DEPTH);

    logic [PW-1:0] alloc_ptr, fill_ptr, rd_ptr, drop_cnt, in_flight;
    logic [PW:0]   occupancy;
    logic          space, accept, rsp_drop, rsp_fill, pop;

    assign in_flight = alloc_ptr - fill_ptr;
    assign occupancy = {1'b0, alloc_ptr - rd_ptr} + {1'b0, drop_cnt};
    assign space     = occupancy < DEPTH_LIM;

    assign IF_PC_plus_4   = PC + INST_ADDR_WIDTH'(cpu_pkg::PC_INC);
    assign imem_req_addr  = PC;
    assign imem_req_valid = inst_request_core2mem & ~flush & space;
    assign accept         = imem_req_valid & imem_req_ready;
    assign stall_PC       = inst_request_core2mem & ~flush & ~accept;

    // A response with nothing outstanding and nothing to drop is a protocol error and is ignored.
    assign rsp_drop = imem_rsp_valid & (drop_cnt != '0);
    assign rsp_fill = imem_rsp_valid & (drop_cnt == '0) & (in_flight != '0);
    assign ID_valid = fill_ptr != rd_ptr;
    assign pop      = ID_valid & ID_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            drop_cnt  <= '0;
        end else if (flush) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            drop_cnt  <= drop_cnt + in_flight - PW'(rsp_drop | rsp_fill);
        end else begin
            alloc_ptr <= alloc_ptr + PW'(accept);
            fill_ptr  <= fill_ptr + PW'(rsp_fill);
            rd_ptr    <= rd_ptr + PW'(pop);
            drop_cnt  <= drop_cnt - PW'(rsp_drop);
        end
    end

    fetch_entry_ram #(
        .INST_ADDR_WIDTH(INST_ADDR_WIDTH),
        .INST_WIDTH(INST_WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk(clk),
        .rst_n(rst_n),
        .alloc_en(accept),
        .alloc_idx(alloc_ptr[IW-1:0]),
        .alloc_pc(PC),
        .fill_en(rsp_fill & ~flush),
        .fill_idx(fill_ptr[IW-1:0]),
        .fill_inst(imem_rsp_data),
        .rd_idx(rd_ptr[IW-1:0]),
        .rd_pc(ID_PC),
        .rd_inst(ID_inst)
    );
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed scenario tests against a fixed-latency memory responder
// whose instruction word for address a is 0xC0DE0000 | a.
module tb_inst_fetch_queue;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [31:0] pc = 0;
    logic        req = 0;
    logic        flush = 0;
    logic [31:0] pc_plus_4;
    logic        stall_PC;
    logic        imem_req_valid;
    logic        imem_req_ready = 0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 0;
    logic [31:0] imem_rsp_data = 0;
    logic        ID_valid;
    logic        id_ready = 0;
    logic [31:0] ID_inst;
    logic [31:0] ID_PC;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    inst_fetch_queue dut (
        .clk(clk),
        .rst_n(rst_n),
        .PC(pc),
        .inst_request_core2mem(req),
        .flush(flush),
        .IF_PC_plus_4(pc_plus_4),
        .stall_PC(stall_PC),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .ID_valid(ID_valid),
        .ID_ready(id_ready),
        .ID_inst(ID_inst),
        .ID_PC(ID_PC)
    );

    always #5 clk = ~clk;

    initial forever @(posedge clk) cyc++;

    // Memory model: responds lat cycles after acceptance, in order; shares reset with the DUT.
    initial forever begin
        mreq_t m;
        @(negedge clk);
        #1;
        imem_rsp_valid = 0;
        if (!rst_n) mq.delete();
        else begin
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid = 1;
                imem_rsp_data  = 32'hC0DE0000 | mq[0].addr;
                void'(mq.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                m.addr = imem_req_addr;
                m.due  = cyc + lat;
                mq.push_back(m);
            end
        end
    end

    task automatic do_reset(input int lat_v);
        @(negedge clk);
        rst_n = 0;
        req = 0;
        flush = 0;
        imem_req_ready = 1;
        id_ready = 0;
        pc = 0;
        lat = lat_v;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 0;
        req = 1;
        imem_req_ready = 0;
        pc = 32'h100;
        @(negedge clk);
        #3;
        checks++;
        if (ID_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%b exp=0", ID_valid); end
        checks++;
        if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL reset_req_valid got=%b exp=1", imem_req_valid); end
        checks++;
        if (stall_PC !== 1'b1) begin failures++; $display("FAIL reset_stall_not_ready got=%b exp=1", stall_PC); end
        checks++;
        if (pc_plus_4 !== 32'h104) begin failures++; $display("FAIL pc_plus_4 got=%h exp=00000104", pc_plus_4); end
        checks++;
        if (imem_req_addr !== 32'h100) begin failures++; $display("FAIL req_addr got=%h exp=00000100", imem_req_addr); end
        @(negedge clk);
        imem_req_ready = 1;
        pc = 32'hFFFFFFFC;
        #3;
        checks++;
        if (stall_PC !== 1'b0) begin failures++; $display("FAIL reset_stall_ready got=%b exp=0", stall_PC); end
        checks++;
        if (pc_plus_4 !== 32'h0) begin failures++; $display("FAIL pc_plus_4_wrap got=%h exp=00000000", pc_plus_4); end
        @(negedge clk);
        req = 0;
        #3;
        checks++;
        if (imem_req_valid !== 1'b0 || stall_PC !== 1'b0) begin
            failures++; $display("FAIL reset_idle got valid=%b stall=%b exp 0 0", imem_req_valid, stall_PC);
        end
    endtask

    task automatic test_zero_wait;
        logic [31:0] e;
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pc = 32'(4 * i);
            req = (i < 6);
            id_ready = 1;
            #3;
            checks++;
            if (stall_PC !== 1'b0) begin failures++; $display("FAIL zero_wait_stall i=%0d got=%b exp=0", i, stall_PC); end
            checks++;
            if (i < 2) begin
                if (ID_valid !== 1'b0) begin failures++; $display("FAIL zero_wait_early i=%0d got=%b exp=0", i, ID_valid); end
            end else begin
                e = 32'(4 * (i - 2));
                if (ID_valid !== 1'b1 || ID_PC !== e || ID_inst !== (32'hC0DE0000 | e)) begin
                    failures++;
                    $display("FAIL zero_wait_data i=%0d got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                             i, ID_valid, ID_PC, ID_inst, e, 32'hC0DE0000 | e);
                end
            end
        end
    endtask

    task automatic test_full;
        logic [31:0] p;
        logic        es;
        do_reset(1);
        p = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pc = p;
            req = 1;
            id_ready = (i >= 6);
            #3;
            es = (i >= 4 && i <= 6);
            checks++;
            if (stall_PC !== es || imem_req_valid !== !es) begin
                failures++;
                $display("FAIL full_stall i=%0d got stall=%b valid=%b exp stall=%b valid=%b", i, stall_PC, imem_req_valid, es, !es);
            end
            if (i == 5) begin
                checks++;
                if (imem_req_addr !== 32'h10) begin failures++; $display("FAIL full_addr_held got=%h exp=00000010", imem_req_addr); end
            end
            if (i == 6 || i == 7) begin
                checks++;
                if (ID_valid !== 1'b1 || ID_PC !== 32'(4 * (i - 6))) begin
                    failures++; $display("FAIL full_pop i=%0d got v=%b pc=%h exp v=1 pc=%h", i, ID_valid, ID_PC, 32'(4 * (i - 6)));
                end
            end
            p = es ? p : p + 4;
        end
        @(negedge clk);
        req = 0;
    endtask

    task automatic test_ready_stall;
        do_reset(1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            pc = 32'h10;
            req = (i < 4);
            imem_req_ready = (i >= 3);
            id_ready = 1;
            #3;
            if (i < 3) begin
                checks++;
                if (stall_PC !== 1'b1 || imem_req_addr !== 32'h10) begin
                    failures++; $display("FAIL rdy_stall i=%0d got stall=%b addr=%h exp stall=1 addr=00000010", i, stall_PC, imem_req_addr);
                end
            end
            if (i == 3) begin
                checks++;
                if (stall_PC !== 1'b0 || imem_req_valid !== 1'b1) begin
                    failures++; $display("FAIL rdy_accept got stall=%b valid=%b exp stall=0 valid=1", stall_PC, imem_req_valid);
                end
            end
            if (i == 5) begin
                checks++;
                if (ID_valid !== 1'b1 || ID_PC !== 32'h10 || ID_inst !== 32'hC0DE0010) begin
                    failures++; $display("FAIL rdy_data got v=%b pc=%h inst=%h exp v=1 pc=00000010 inst=c0de0010", ID_valid, ID_PC, ID_inst);
                end
            end
            if (i == 4 || i == 6) begin
                checks++;
                if (ID_valid !== 1'b0) begin failures++; $display("FAIL rdy_single i=%0d got v=%b exp=0", i, ID_valid); end
            end
        end
    endtask

    task automatic test_flush_drop;
        do_reset(3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pc = (i < 3) ? 32'(4 * i) : 32'h40;
            req = (i <= 4);
            flush = (i == 3);
            id_ready = 1;
            #3;
            if (i == 3) begin
                checks++;
                if (stall_PC !== 1'b0 || imem_req_valid !== 1'b0) begin
                    failures++; $display("FAIL flush_cycle got stall=%b valid=%b exp 0 0", stall_PC, imem_req_valid);
                end
            end
            if (i == 4) begin
                checks++;
                if (imem_req_valid !== 1'b1 || stall_PC !== 1'b0) begin
                    failures++; $display("FAIL flush_refetch got valid=%b stall=%b exp 1 0", imem_req_valid, stall_PC);
                end
            end
            if (i <= 7 || i == 9) begin
                checks++;
                if (ID_valid !== 1'b0) begin failures++; $display("FAIL flush_quiet i=%0d got v=%b exp=0", i, ID_valid); end
            end
            if (i == 8) begin
                checks++;
                if (ID_valid !== 1'b1 || ID_PC !== 32'h40 || ID_inst !== 32'hC0DE0040) begin
                    failures++; $display("FAIL flush_target got v=%b pc=%h inst=%h exp v=1 pc=00000040 inst=c0de0040", ID_valid, ID_PC, ID_inst);
                end
            end
        end
    endtask

    task automatic test_flush_rsp_pop;
        do_reset(2);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            pc = (i < 3) ? 32'(4 * i) : 32'h80;
            req = (i < 3) || (i == 4);
            flush = (i == 3);
            id_ready = 1;
            #3;
            if (i == 3) begin
                checks++;
                if (ID_valid !== 1'b1 || ID_PC !== 32'h0) begin
                    failures++; $display("FAIL frp_head got v=%b pc=%h exp v=1 pc=00000000", ID_valid, ID_PC);
                end
            end
            if (i >= 4 && i <= 6) begin
                checks++;
                if (ID_valid !== 1'b0) begin failures++; $display("FAIL frp_quiet i=%0d got v=%b exp=0", i, ID_valid); end
            end
            if (i == 7) begin
                checks++;
                if (ID_valid !== 1'b1 || ID_PC !== 32'h80 || ID_inst !== 32'hC0DE0080) begin
                    failures++; $display("FAIL frp_target got v=%b pc=%h inst=%h exp v=1 pc=00000080 inst=c0de0080", ID_valid, ID_PC, ID_inst);
                end
            end
        end
    endtask

    task automatic test_reset_midstream;
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pc = (i == 1) ? 32'h4 : 32'h0;
            req = (i < 2) || (i == 4);
            rst_n = (i != 3);
            id_ready = (i >= 4);
            #3;
            if (i == 3) begin
                checks++;
                if (ID_valid !== 1'b1 || ID_PC !== 32'h0) begin
                    failures++; $display("FAIL rstm_before got v=%b pc=%h exp v=1 pc=00000000", ID_valid, ID_PC);
                end
            end
            if (i == 4 || i == 5 || i == 7) begin
                checks++;
                if (ID_valid !== 1'b0) begin failures++; $display("FAIL rstm_empty i=%0d got v=%b exp=0", i, ID_valid); end
            end
            if (i == 6) begin
                checks++;
                if (ID_valid !== 1'b1 || ID_PC !== 32'h0 || ID_inst !== 32'hC0DE0000) begin
                    failures++; $display("FAIL rstm_resume got v=%b pc=%h inst=%h exp v=1 pc=00000000 inst=c0de0000", ID_valid, ID_PC, ID_inst);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_full();
        test_ready_stall();
        test_flush_drop();
        test_flush_rsp_pop();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
